// File: rtl/icache_pkg.sv
// Shared definitions for the RVC-aware set-associative instruction cache:
// line geometry, refill FSM states, and the RVC full-width opcode marker.
package icache_pkg;

  localparam int LINE_W      = 128;
  localparam int HW_W        = 16;
  localparam int HW_PER_LINE = 8;
  localparam int LINE_ADDR_W = 28;

  // Low two bits of a halfword that mark the start of a 32-bit instruction.
  localparam logic [1:0] RVC_FULL = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REFILL_A = 2'd1,
    REFILL_B = 2'd2
  } state_t;

  // Extract halfword idx from a cache line (halfword k lives at bits [16k+15:16k]).
  function automatic logic [HW_W-1:0] line_hw(input logic [LINE_W-1:0] line,
                                               input logic [2:0]        idx);
    return line[{idx, 4'b0000} +: HW_W];
  endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the cache: valid bits, tags and line data for NUM_SETS sets.
// Two independent lookup ports (line A and line B of a cross-line fetch)
// and one write port used by the refill engine.
module icache_way
  import icache_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int SET_W    = 3,
  parameter int TAG_W    = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SET_W-1:0]    set_a,
  input  logic [TAG_W-1:0]    tag_a,
  output logic                hit_a,
  output logic [LINE_W-1:0]   data_a,
  input  logic [SET_W-1:0]    set_b,
  input  logic [TAG_W-1:0]    tag_b,
  output logic                hit_b,
  output logic [LINE_W-1:0]   data_b,
  input  logic                wr_en,
  input  logic [SET_W-1:0]    wr_set,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [LINE_W-1:0]   wr_data,
  output logic [NUM_SETS-1:0] valid
);

  logic [TAG_W-1:0]  tags [NUM_SETS];
  logic [LINE_W-1:0] data [NUM_SETS];

  // Valid bits: cleared by reset, set when a refill installs into this way.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_set] <= 1'b1;
    end
  end

  // Tag and data storage: written on install only.
  always_ff @(posedge clk) begin
    // NOTE: tag/data arrays are deliberately not reset; the valid bit gates
    // their use, which lets synthesis map them onto plain RAM.
    if (wr_en) begin
      tags[wr_set] <= wr_tag;
      data[wr_set] <= wr_data;
    end
  end

  assign hit_a  = valid[set_a] && (tags[set_a] == tag_a);
  assign data_a = data[set_a];
  assign hit_b  = valid[set_b] && (tags[set_b] == tag_b);
  assign data_b = data[set_b];

endmodule

// File: rtl/icache_rvc_assoc.sv
// Set-associative instruction cache for RISC-V fetch with compressed (RVC)
// support. A 32-bit instruction at halfword offset 7 straddles two lines,
// so both line A and line B are looked up in parallel every cycle.
module icache_rvc_assoc
  import icache_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int NUM_WAYS = 2,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   proc_read,
  input  logic [30:0]            proc_addr,
  output logic [31:0]            proc_rdata,
  output logic                   proc_stall,
  output logic                   proc_pcadd,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [LINE_ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]      mem_wdata,
  input  logic [LINE_W-1:0]      mem_rdata,
  input  logic                   mem_ready,
  output logic [CNT_W-1:0]       hit_cnt,
  output logic [CNT_W-1:0]       miss_cnt
);

  localparam int SET_W = $clog2(NUM_SETS);
  localparam int TAG_W = LINE_ADDR_W - SET_W;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  state_t state;

  logic [LINE_ADDR_W-1:0] line_a;
  logic [LINE_ADDR_W-1:0] line_b;
  logic [2:0]             off;

  logic [NUM_WAYS-1:0]    way_hit_a;
  logic [NUM_WAYS-1:0]    way_hit_b;
  logic [LINE_W-1:0]      way_data_a [NUM_WAYS];
  logic [LINE_W-1:0]      way_data_b [NUM_WAYS];
  logic [NUM_SETS-1:0]    way_valid  [NUM_WAYS];

  logic                   hit_a;
  logic                   hit_b;
  logic [LINE_W-1:0]      data_a;
  logic [LINE_W-1:0]      data_b;
  logic [HW_W-1:0]        h0;
  logic [HW_W-1:0]        h1;
  logic                   full;
  logic                   need_b;
  logic                   hit_all;

  logic                   install;
  logic [SET_W-1:0]       ins_set;
  logic [TAG_W-1:0]       ins_tag;
  logic [WAY_W-1:0]       victim;
  logic [WAY_W-1:0]       rr [NUM_SETS];
  logic                   fetch_missed;

  assign line_a  = proc_addr[30:3];
  assign off     = proc_addr[2:0];
  assign line_b  = line_a + 1'b1;

  assign install = (state != IDLE) && mem_ready;
  assign ins_set = mem_addr[SET_W-1:0];
  assign ins_tag = mem_addr[LINE_ADDR_W-1:SET_W];

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    icache_way #(
      .NUM_SETS (NUM_SETS),
      .SET_W    (SET_W),
      .TAG_W    (TAG_W)
    ) u_way (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_a   (line_a[SET_W-1:0]),
      .tag_a   (line_a[LINE_ADDR_W-1:SET_W]),
      .hit_a   (way_hit_a[w]),
      .data_a  (way_data_a[w]),
      .set_b   (line_b[SET_W-1:0]),
      .tag_b   (line_b[LINE_ADDR_W-1:SET_W]),
      .hit_b   (way_hit_b[w]),
      .data_b  (way_data_b[w]),
      .wr_en   (install && (victim == WAY_W'(w))),
      .wr_set  (ins_set),
      .wr_tag  (ins_tag),
      .wr_data (mem_rdata),
      .valid   (way_valid[w])
    );
  end

  // Merge per-way lookups; tags are unique within a set, so OR-ing is a mux.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    hit_a  = 1'b0;
    hit_b  = 1'b0;
    data_a = '0;
    data_b = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_a = hit_a | way_hit_a[w];
      hit_b = hit_b | way_hit_b[w];
      if (way_hit_a[w]) data_a = data_a | way_data_a[w];
      if (way_hit_b[w]) data_b = data_b | way_data_b[w];
    end
  end

  // Instruction assembly: upper half comes from the next halfword of line A,
  // or from halfword 0 of line B when the instruction straddles lines.
  always_comb begin
    h0     = line_hw(data_a, off);
    full   = (h0[1:0] == RVC_FULL);
    need_b = full && (off == 3'd7);
    h1     = need_b ? line_hw(data_b, 3'd0) : line_hw(data_a, off + 3'd1);
    hit_all    = hit_a && (!need_b || hit_b);
    proc_rdata = full ? {h1, h0} : {16'h0000, h0};
    proc_pcadd = !full;
    proc_stall = (state != IDLE) || (proc_read && !hit_all);
  end

  // Victim choice for the set being refilled: lowest invalid way, else round-robin.
  always_comb begin
    victim = rr[ins_set];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w][ins_set]) victim = WAY_W'(w);
    end
  end

  // Per-set round-robin pointers advance on every install into that set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) rr[s] <= '0;
    end else if (install) begin
      rr[ins_set] <= (rr[ins_set] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr[ins_set] + 1'b1;
    end
  end

  // Refill FSM with registered memory request and saturating perf counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      mem_read     <= 1'b0;
      mem_addr     <= '0;
      fetch_missed <= 1'b0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (proc_read) begin
            if (!hit_a) begin
              state        <= REFILL_A;
              mem_read     <= 1'b1;
              mem_addr     <= line_a;
              fetch_missed <= 1'b1;
              if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end else if (need_b && !hit_b) begin
              state        <= REFILL_B;
              mem_read     <= 1'b1;
              mem_addr     <= line_b;
              fetch_missed <= 1'b1;
              if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end else begin
              fetch_missed <= 1'b0;
              if (!fetch_missed && (hit_cnt != '1)) hit_cnt <= hit_cnt + 1'b1;
            end
          end
        end
        REFILL_A, REFILL_B: begin
          if (mem_ready) begin
            state    <= IDLE;
            mem_read <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          mem_read <= 1'b0;
        end
      endcase
    end
  end

  assign mem_write = 1'b0;
  assign mem_wdata = '0;

endmodule

// File: tb/tb_icache_rvc_assoc.sv
// Self-checking bench for icache_rvc_assoc: a behavioural cache model (sets of
// resident line numbers, expected data taken straight from the memory image)
// is compared against the DUT every cycle, plus directed literal expectations.
module tb_icache_rvc_assoc;

  localparam int NS  = 8;
  localparam int NW  = 2;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          proc_read;
  logic [30:0]   proc_addr;
  logic [31:0]   proc_rdata;
  logic          proc_stall;
  logic          proc_pcadd;
  logic          mem_read;
  logic          mem_write;
  logic [27:0]   mem_addr;
  logic [127:0]  mem_wdata;
  logic [127:0]  mem_rdata;
  logic          mem_ready;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  icache_rvc_assoc #(.NUM_SETS(NS), .NUM_WAYS(NW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_addr  (proc_addr),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .proc_pcadd (proc_pcadd),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory image: a few planted instructions, otherwise compressed filler.
  function automatic logic [15:0] mem_hw(input logic [27:0] l, input int k);
    logic [2:0] k3;
    k3 = k[2:0];
    if (l == 28'h0 && k == 2) return 16'h4501;
    if (l == 28'h0 && k == 4) return 16'h0093;
    if (l == 28'h0 && k == 5) return 16'h00A0;
    if (l == 28'h10 && k == 7) return 16'h2003;
    if (l == 28'hFFFFFFF && k == 7) return 16'h5673;
    return {l[8:0], k3, 4'b0001};
  endfunction

  function automatic logic [127:0] mem_line(input logic [27:0] l);
    logic [127:0] v;
    for (int k = 0; k < 8; k++) v[16*k +: 16] = mem_hw(l, k);
    return v;
  endfunction

  // Memory responder: mem_ready on the lat-th cycle of mem_read.
  int lat = 3;
  int rcnt = 0;
  logic [27:0] refill_log[$];

  always @(posedge clk) begin
    #2;
    if (mem_read === 1'b1) begin
      rcnt++;
      if (rcnt == 1) refill_log.push_back(mem_addr);
      mem_ready = (rcnt == lat);
      mem_rdata = mem_line(mem_addr);
    end else begin
      rcnt      = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
    end
  end

  // Behavioural model: resident line numbers per set/slot, -1 = empty.
  typedef struct {
    bit          stall;
    bit          start;
    logic [27:0] miss_line;
    bit          done;
    logic [31:0] rdata;
    bit          pcadd;
  } exp_t;

  int   res [NS][NW];
  int   rr_m [NS];
  int   m_hit;
  int   m_miss;
  int   busy;
  bit   fmiss;
  bit   live = 1'b0;
  exp_t e_cmp;
  exp_t e_upd;

  function automatic bit resident(input logic [27:0] l);
    int s;
    s = int'(l) % NS;
    for (int w = 0; w < NW; w++) if (res[s][w] == int'(l)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void install(input int l);
    int s;
    int sel;
    s   = l % NS;
    sel = -1;
    for (int w = 0; w < NW; w++) if (res[s][w] < 0 && sel < 0) sel = w;
    if (sel < 0) sel = rr_m[s];
    res[s][sel] = l;
    rr_m[s] = (rr_m[s] + 1) % NW;
  endfunction

  function automatic exp_t evaluate();
    exp_t        e;
    logic [27:0] la;
    logic [27:0] lb;
    int          off;
    logic [15:0] h0;
    logic [15:0] hi;
    bit          full;
    e = '{default: 0};
    la  = proc_addr[30:3];
    lb  = la + 28'd1;
    off = int'(proc_addr[2:0]);
    if (busy >= 0) begin
      e.stall = 1'b1;
    end else if (proc_read) begin
      h0   = mem_hw(la, off);
      full = (h0[1:0] == 2'b11);
      hi   = (off == 7) ? mem_hw(lb, 0) : mem_hw(la, off + 1);
      e.rdata = full ? {hi, h0} : {16'h0000, h0};
      e.pcadd = !full;
      if (!resident(la)) begin
        e.start = 1'b1; e.miss_line = la; e.stall = 1'b1;
      end else if (full && off == 7 && !resident(lb)) begin
        e.start = 1'b1; e.miss_line = lb; e.stall = 1'b1;
      end else begin
        e.done = 1'b1;
      end
    end
    return e;
  endfunction

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (live) begin
      e_cmp = evaluate();
      check("proc_stall", proc_stall, e_cmp.stall);
      if (e_cmp.done) begin
        check("proc_rdata", proc_rdata, e_cmp.rdata);
        check("proc_pcadd", proc_pcadd, e_cmp.pcadd);
      end
      check("mem_read", mem_read, busy >= 0);
      if (busy >= 0) check("mem_addr", mem_addr, busy);
      check("mem_write", mem_write, 1'b0);
      check("mem_wdata", mem_wdata[63:0] | mem_wdata[127:64], 64'h0);
      check("hit_cnt", hit_cnt, m_hit);
      check("miss_cnt", miss_cnt, m_miss);
    end
  end

  // Model state advance at the clock edge.
  always @(posedge clk) begin
    if (rst_n === 1'b0) begin
      live   = 1'b1;
      busy   = -1;
      fmiss  = 1'b0;
      m_hit  = 0;
      m_miss = 0;
      for (int s = 0; s < NS; s++) begin
        rr_m[s] = 0;
        for (int w = 0; w < NW; w++) res[s][w] = -1;
      end
    end else if (live) begin
      e_upd = evaluate();
      if (busy >= 0) begin
        if (mem_ready) begin
          install(busy);
          busy = -1;
        end
      end else if (e_upd.start) begin
        busy  = int'(e_upd.miss_line);
        fmiss = 1'b1;
        if (m_miss < MAX) m_miss++;
      end else if (e_upd.done) begin
        if (!fmiss && m_hit < MAX) m_hit++;
        fmiss = 1'b0;
      end
    end
  end

  task automatic fetch(input logic [30:0] a, output int stalls,
                       output logic [31:0] rd, output logic pc);
    bit done;
    done = 1'b0;
    proc_addr = a;
    proc_read = 1'b1;
    stalls = 0;
    rd = '0;
    pc = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (proc_stall === 1'b0) begin
        done = 1'b1;
        rd = proc_rdata;
        pc = proc_pcadd;
        break;
      end
      stalls++;
    end
    check("fetch_done", done, 1'b1);
    @(posedge clk);
    #1;
    proc_read = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    refill_log.delete();
  endtask

  int          st;
  logic [31:0] rd;
  logic        pc;
  bit          saw_read;

  initial begin
    rst_n = 1'b0; proc_read = 1'b0; proc_addr = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_stall", proc_stall, 1'b0);
    @(posedge clk); #1;

    // Cold fetch of byte 0: one refill of line 0, four stall cycles.
    fetch(31'h0, st, rd, pc);
    check("cold_stalls", st, 4);
    check("cold_rdata", rd, 32'h00000001);
    check("cold_log_size", refill_log.size(), 1);
    if (refill_log.size() > 0) check("cold_log_addr", refill_log[0], 28'h0);
    fetch(31'h0, st, rd, pc);
    check("warm_stalls", st, 0);
    check("cold_miss_cnt", miss_cnt, 1);
    check("cold_hit_cnt", hit_cnt, 1);

    // Compressed at offset 2, full-width spanning offsets 4/5.
    fetch(31'h2, st, rd, pc);
    check("rvc_rdata", rd, 32'h00004501);
    check("rvc_pcadd", pc, 1'b1);
    fetch(31'h4, st, rd, pc);
    check("full_rdata", rd, 32'h00A00093);
    check("full_pcadd", pc, 1'b0);

    // Full-width at offset 7 of line 0x10, both lines cold.
    refill_log.delete();
    fetch(31'h87, st, rd, pc);
    check("cross_stalls", st, 8);
    check("cross_rdata", rd, 32'h08812003);
    check("cross_pcadd", pc, 1'b0);
    check("cross_miss_cnt", miss_cnt, 3);
    check("cross_hit_cnt", hit_cnt, 3);
    check("cross_log_size", refill_log.size(), 2);
    if (refill_log.size() == 2) begin
      check("cross_log_a", refill_log[0], 28'h10);
      check("cross_log_b", refill_log[1], 28'h11);
    end

    // Round-robin eviction in set 0.
    do_reset();
    fetch(31'h000, st, rd, pc);
    fetch(31'h040, st, rd, pc);
    fetch(31'h080, st, rd, pc);
    fetch(31'h000, st, rd, pc);
    check("evict_00_stalls", st, 4);
    fetch(31'h040, st, rd, pc);
    check("evict_08_stalls", st, 4);
    check("evict_miss_cnt", miss_cnt, 5);
    check("evict_hit_cnt", hit_cnt, 0);
    fetch(31'h000, st, rd, pc);
    check("evict_00_hit", st, 0);
    check("evict_hit_cnt2", hit_cnt, 1);

    // Refill latency variation.
    lat = 1;
    fetch(31'h100, st, rd, pc);
    check("lat1_stalls", st, 2);
    lat = 5;
    fetch(31'h180, st, rd, pc);
    check("lat5_stalls", st, 6);
    lat = 3;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a refill.
    proc_addr = 31'h200;
    proc_read = 1'b1;
    saw_read = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mem_read === 1'b1) begin
        saw_read = 1'b1;
        break;
      end
    end
    check("abort_saw_read", saw_read, 1'b1);
    rst_n = 1'b0;
    proc_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_mem_read", mem_read, 1'b0);
    check("abort_hit_cnt", hit_cnt, 0);
    check("abort_miss_cnt", miss_cnt, 0);
    @(posedge clk); #1;
    fetch(31'h200, st, rd, pc);
    check("abort_refetch_stalls", st, 4);
    check("abort_refetch_miss", miss_cnt, 1);

    // Top line wraps to line 0 for the second half.
    do_reset();
    fetch(31'h7FFFFFFF, st, rd, pc);
    check("wrap_stalls", st, 8);
    check("wrap_rdata", rd, 32'h00015673);
    check("wrap_pcadd", pc, 1'b0);
    check("wrap_log_size", refill_log.size(), 2);
    if (refill_log.size() == 2) begin
      check("wrap_log_a", refill_log[0], 28'hFFFFFFF);
      check("wrap_log_b", refill_log[1], 28'h0);
    end

    // Counter saturation.
    for (int i = 0; i < 20; i++) fetch(31'h7FFFFFFF, st, rd, pc);
    check("sat_hit_cnt", hit_cnt, MAX);
    lat = 1;
    for (int i = 0; i < 14; i++) fetch(31'((32'h100 + i) << 3), st, rd, pc);
    check("sat_miss_cnt", miss_cnt, MAX);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/icache_rvc_assoc.md
ICACHE_RVC_ASSOC -- requirements
Module: icache_rvc_assoc

Interface
REQ-001 SHALL have parameter NUM_SETS, default 8, number of sets (power of 2, 2..256).
REQ-002 SHALL have parameter NUM_WAYS, default 2, associativity (1, 2 or 4).
REQ-003 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-004 clk  input  1  the single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 proc_read  input  1  fetch request.
REQ-007 proc_addr  input  31  halfword fetch address; byte address = {proc_addr,1'b0}.
REQ-008 proc_rdata  output  32  fetched instruction.
REQ-009 proc_stall  output  1  fetch not yet complete.
REQ-010 proc_pcadd  output  1  1 = compressed (PC+2), 0 = full-width (PC+4).
REQ-011 mem_read  output  1  line refill request.
REQ-012 mem_write  output  1  constant 0.
REQ-013 mem_addr  output  28  refill line address, byte address bits [31:4].
REQ-014 mem_wdata  output  128  constant 0.
REQ-015 mem_rdata  input  128  refill line data, halfword k at bits [16k+15:16k].
REQ-016 mem_ready  input  1  refill data valid.
REQ-017 hit_cnt  output  CNT_W  count of fetches completed without a refill.
REQ-018 miss_cnt  output  CNT_W  count of line refills issued.

Function
REQ-019 SHALL decode proc_addr as: line = proc_addr[30:3], halfword offset = proc_addr[2:0], set = line mod NUM_SETS, tag = remaining upper line bits.
REQ-020 SHALL define line A as the line addressed by proc_addr, and line B as line A + 1 modulo 2^28 (0x0FFFFFFF wraps to 0).
REQ-021 SHALL read halfword h0 at the requested offset and set proc_pcadd = (h0[1:0] != 2'b11).
REQ-022 For a compressed fetch, SHALL drive proc_rdata = {16'h0, h0}.
REQ-023 For a full-width fetch at offset < 7, SHALL drive proc_rdata = next halfword of line A concatenated with h0, h0 in the low half.
REQ-024 For a full-width fetch at offset 7, SHALL drive proc_rdata = {halfword 0 of line B, h0}; both lines must hit.
REQ-025 SHALL use FSM states IDLE, REFILL_A and REFILL_B.
REQ-026 IDLE, proc_read = 1, all needed lines hit: proc_stall = 0 and proc_rdata valid combinationally in the same cycle; stay in IDLE.
REQ-027 IDLE, line A misses: proc_stall = 1 and go to REFILL_A.
REQ-028 IDLE, line A hits but line B is needed and misses: proc_stall = 1 and go to REFILL_B.
REQ-029 In REFILL_A/REFILL_B, SHALL hold mem_read = 1 and mem_addr = the missing line, stable, until mem_ready is sampled 1.
REQ-030 On the mem_ready cycle: install the line into the victim way, set its valid bit and tag, go to IDLE; mem_read = 0 the following cycle.
REQ-031 SHALL keep proc_stall = 1 in every state except an IDLE hit; a full miss costs (refill cycles + 1) stalled cycles.
REQ-032 Victim selection: lowest-numbered invalid way, else the per-set round-robin pointer.
REQ-033 Round-robin pointer SHALL advance by 1 modulo NUM_WAYS on each install into that set.
REQ-034 When proc_read = 0: proc_stall = 0, no state change, counters unchanged, proc_rdata don't-care.
REQ-035 SHALL increment hit_cnt once per fetch completing in IDLE with no refill in that fetch.
REQ-036 SHALL increment miss_cnt once per refill issued; a cross-line double miss counts 2.
REQ-037 hit_cnt and miss_cnt SHALL saturate at all-ones.
REQ-038 mem_addr SHALL be don't-care while mem_read = 0.

Reset
REQ-039 When rst_n = 0 at a clock edge, SHALL clear all valid bits, round-robin pointers, hit_cnt and miss_cnt.
REQ-040 Reset SHALL force the state to IDLE and mem_read = 0 from the next cycle, including during a refill.
REQ-041 A refill in progress at reset SHALL be abandoned and its line not installed; data arrays are not cleared.

Structure
REQ-042 Shared package icache_pkg SHALL hold: line width 128, HW_PER_LINE = 8, the FSM state enum, and the RVC full-width opcode constant 2'b11.
REQ-043 SHALL use one sub-module, icache_way (valid/tag/data storage for one way, NUM_SETS entries), instantiated NUM_WAYS times.

Verification
REQ-044 Cold fetch 0x000 (byte 0x0), memory returns line after 3 cycles -> one mem_read for mem_addr 0x0, stall 4 cycles, then hit; miss_cnt = 1, hit_cnt = 1.
REQ-045 Line holds 16'h4501 at offset 2 -> fetch offset 2 gives proc_pcadd = 1, proc_rdata = 32'h00004501; 32'h00A00093 at offsets 4/5 gives proc_pcadd = 0, proc_rdata = 32'h00A00093.
REQ-046 Full-width instruction at offset 7 of line 0x10, both lines cold -> two refills (0x10, then 0x11), miss_cnt += 2, proc_rdata = {line 0x11 halfword 0, h0}.
REQ-047 NUM_WAYS = 2, NUM_SETS = 8: lines 0x00, 0x08, 0x10 fetched, then 0x00 -> 0x10 evicts 0x00 and the 0x00 re-fetch misses; 0x08 no longer hits either (evicted by the 0x00 refill).
REQ-048 rst_n = 0 while mem_read = 1 -> mem_read = 0 next cycle; re-fetch of the same address misses; counters = 0.
REQ-049 Line 0x0FFFFFFF, full-width instruction at offset 7 -> second refill issued with mem_addr = 0x0000000.
